if_stage: RTL

//  Instruction-fetch stage that feeds the ID stage. Holds the PC and selects next-PC from ID's PCSrcID/targets.

---
 rtl/mips_pipe_pkg.sv | 38 +++
 rtl/if_id_reg.sv | 48 ++++
 rtl/if_stage.sv | 97 +++++++++
 3 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the MIPS fetch/decode boundary.
// ID's Control/PCSrc logic imports the same encodings.
package mips_pipe_pkg;

   localparam logic [2:0]  PCSRC_SEQ = 3'd0;
   localparam logic [2:0]  PCSRC_BR  = 3'd1;
   localparam logic [2:0]  PCSRC_J   = 3'd2;
   localparam logic [2:0]  PCSRC_JR  = 3'd3;
   localparam logic [2:0]  PCSRC_EXC = 3'd4;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
   localparam logic [31:0] IRQ_VEC_DEFAULT  = 32'h8000_0004;
   localparam logic [31:0] EXC_VEC_DEFAULT  = 32'h8000_0008;
   localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

   typedef struct packed {
      logic [31:0] instruction;
      logic [31:0] pcPlus4;
      logic [31:0] pc;
      logic        valid;
      logic        irqTaken;
   } ifIdT;

   localparam ifIdT IFID_BUBBLE = '{instruction: NOP_INSTR, pcPlus4: 32'h0000_0000,
                                    pc: 32'h0000_0000, valid: 1'b0, irqTaken: 1'b0};

   // Reserved encodings 5-7 fall back to sequential fetch.
   function automatic logic isRedirect(input logic [2:0] pcSrc);
      return (pcSrc >= PCSRC_BR) && (pcSrc <= PCSRC_EXC);
   endfunction

   // Sequential successor, 32-bit modulo (0xFFFF_FFFC wraps to 0).
   function automatic logic [31:0] seqPc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: hold on stall, NOP bubble load, and interrupt-entry tagging.
// irqEntry outranks hold; the top only asserts it when the stage is not stalled.
module if_id_reg
   import mips_pipe_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        hold,
   input  logic        bubble,
   input  logic        irqEntry,
   input  logic [31:0] resumePc,
   input  logic [31:0] fetchInstr,
   input  logic [31:0] fetchPcPlus4,
   input  logic [31:0] fetchPc,
   output logic [31:0] instructionID,
   output logic [31:0] PCplus4ID,
   output logic [31:0] PCID,
   output logic        validID,
   output logic        irq_takenID
);

   ifIdT stage_r;

   // IF/ID state update in priority order: reset, irq entry, hold, bubble, fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_r <= IFID_BUBBLE;
      end else if (irqEntry) begin
         stage_r          <= IFID_BUBBLE;
         stage_r.pcPlus4  <= resumePc;
         stage_r.irqTaken <= 1'b1;
      end else if (hold) begin
         stage_r <= stage_r;
      end else if (bubble) begin
         stage_r <= IFID_BUBBLE;
      end else begin
         stage_r <= '{instruction: fetchInstr, pcPlus4: fetchPcPlus4,
                      pc: fetchPc, valid: 1'b1, irqTaken: 1'b0};
      end
   end

   assign instructionID = stage_r.instruction;
   assign PCplus4ID     = stage_r.pcPlus4;
   assign PCID          = stage_r.pc;
   assign validID       = stage_r.valid;
   assign irq_takenID   = stage_r.irqTaken;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and priority between
// interrupt entry, load-use stall, redirect and imem wait-states.
module if_stage
   import mips_pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] IRQ_VEC  = IRQ_VEC_DEFAULT,
   parameter logic [31:0] EXC_VEC  = EXC_VEC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        intterupt,
   input  logic [2:0]  PCSrcID,
   input  logic [31:0] branchaddrID,
   input  logic [31:0] jumpaddrID,
   input  logic [31:0] jraddrID,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] instructionID,
   output logic [31:0] PCplus4ID,
   output logic [31:0] PCID,
   output logic        validID,
   output logic        irq_takenID
);

   logic [31:0] pc_r;
   logic [31:0] pcPlus4_s;
   logic [31:0] target_s;
   logic [31:0] resumePc_s;
   logic        redirect_s;
   logic        irqOk_s;

   assign pcPlus4_s  = seqPc(pc_r);
   assign redirect_s = isRedirect(PCSrcID);
   // Kernel space (PC[31]=1) masks the level-sensitive request, preventing re-entry.
   assign irqOk_s    = intterupt & ~stall & ~pc_r[31];

   // Redirect target mux; jr drops the low two bits to keep the PC word-aligned.
   always_comb begin
      target_s = pc_r;
      case (PCSrcID)
         PCSRC_BR:  target_s = branchaddrID;
         PCSRC_J:   target_s = jumpaddrID;
         PCSRC_JR:  target_s = jraddrID & PC_ALIGN_MASK;
         PCSRC_EXC: target_s = EXC_VEC;
         default:   target_s = pc_r;
      endcase
   end

   // Resume PC recorded for EPC: the pending redirect wins over the discarded fetch.
   always_comb begin
      if (redirect_s) begin
         resumePc_s = target_s;
      end else begin
         resumePc_s = pc_r;
      end
   end

   // PC register with the same priority as the IF/ID register.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r <= RESET_PC;
      end else if (irqOk_s) begin
         pc_r <= IRQ_VEC;
      end else if (stall) begin
         pc_r <= pc_r;
      end else if (redirect_s) begin
         pc_r <= target_s;
      end else if (imem_ready) begin
         pc_r <= pcPlus4_s;
      end else begin
         pc_r <= pc_r;
      end
   end

   assign imem_addr = pc_r;

   if_id_reg u_if_id_reg (
      .clk          (clk),
      .reset        (reset),
      .hold         (stall),
      .bubble       (redirect_s | ~imem_ready),
      .irqEntry     (irqOk_s),
      .resumePc     (resumePc_s),
      .fetchInstr   (imem_rdata),
      .fetchPcPlus4 (pcPlus4_s),
      .fetchPc      (pc_r),
      .instructionID(instructionID),
      .PCplus4ID    (PCplus4ID),
      .PCID         (PCID),
      .validID      (validID),
      .irq_takenID  (irq_takenID)
   );

endmodule
